// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bus bundle: hazard-unit controls, instruction-memory
// port and the IF/ID pipeline register outputs.
// The master modport is the fetch stage; the slave modport is its environment
// (hazard unit, instruction memory and decoder).
interface instruction_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_target;
  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction;
  logic [INSTR_W-1:0] if_id_instruction;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;

  modport master (
    input  stall,
    input  redirect,
    input  redirect_target,
    output imem_address,
    input  imem_instruction,
    output if_id_instruction,
    output if_id_pc,
    output if_id_valid
  );

  modport slave (
    output stall,
    output redirect,
    output redirect_target,
    input  imem_address,
    output imem_instruction,
    input  if_id_instruction,
    input  if_id_pc,
    input  if_id_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Mini-MIPS instruction-fetch stage. Owns the PC, presents a word address to a
// synchronous (one-cycle latency) instruction memory and captures the returned
// instruction into the IF/ID register. Supports stalls (replay the in-flight
// address) and redirects (flush the wrong-path instruction, one bubble).
module instruction_fetch #(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input logic              clk,
  input logic              rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(1);

  // pc: next sequential address; fetch_pc: address presented last cycle,
  // whose data is on imem_instruction now; fetch_valid: that data is usable.
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0]  imem_address_w;

  // Address mux: redirect first, then replay the in-flight address on stall,
  // otherwise the next sequential PC.
  always_comb begin
    imem_address_w = pc_q;
    if (bus.redirect) begin
      imem_address_w = bus.redirect_target;
    end else if (bus.stall) begin
      imem_address_w = fetch_pc_q;
    end
  end

  // Next-state: redirect flushes IF/ID and restarts at the target, stall
  // freezes everything, otherwise advance one instruction per cycle.
  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if (bus.redirect) begin
      pc_d          = bus.redirect_target + PC_STEP;
      fetch_pc_d    = bus.redirect_target;
      fetch_valid_d = 1'b1;
      if_id_valid_d = 1'b0;
    end else if (!bus.stall) begin
      if_id_instr_d = bus.imem_instruction;
      if_id_pc_d    = fetch_pc_q;
      if_id_valid_d = fetch_valid_q;
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b1;
      pc_d          = pc_q + PC_STEP;
    end
  end

  // State registers; asynchronous reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_W;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign bus.imem_address      = imem_address_w;
  assign bus.if_id_instruction = if_id_instr_q;
  assign bus.if_id_pc          = if_id_pc_q;
  assign bus.if_id_valid       = if_id_valid_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the Mini-MIPS core. It owns the program counter, drives the word address into `instruction_memory` and captures the returned 16-bit instruction into the IF/ID pipeline register for the decoder. It supports pipeline stalls and taken-branch/jump redirects, and accounts for the one-cycle synchronous read latency of `instruction_memory`.

## Interface
Parameters:
- `ADDR_W`, 32, width of the PC and the instruction-memory address.
- `INSTR_W`, 16, instruction width.
- `RESET_PC`, 0, word address of the first instruction fetched after reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold request from the hazard unit; freezes PC and IF/ID.
- `redirect`  in  1  taken branch or jump; has priority over `stall`.
- `redirect_target`  in  ADDR_W  word address to fetch from on `redirect`.
- `imem_address`  out  ADDR_W  address to `instruction_memory`; combinational.
- `imem_instruction`  in  INSTR_W  data from `instruction_memory`, valid for the address presented in the previous cycle.
- `if_id_instruction`  out  INSTR_W  registered instruction to decode.
- `if_id_pc`  out  ADDR_W  word address of `if_id_instruction`.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- Internal registers:
  - `pc`: the next sequential address to present.
  - `fetch_pc`: the address presented last cycle; its data is on `imem_instruction` now.
  - `fetch_valid`: whether that in-flight data is usable.
- Address mux, in priority order:
  - `redirect`: `redirect_target`.
  - else `stall`: `fetch_pc`. This replays the in-flight address, so its data re-appears next cycle and is not lost.
  - else: `pc`.
- Edge update, `redirect` = 1 (regardless of `stall`):
  - `pc <= redirect_target + 1`
  - `fetch_pc <= redirect_target`
  - `fetch_valid <= 1`
  - `if_id_valid <= 0`; the wrong-path instruction is flushed. `if_id_instruction` and `if_id_pc` are don't-care.
- Edge update, `stall` = 1 and `redirect` = 0:
  - All registers hold, including `if_id_*`.
- Edge update, normal:
  - `if_id_instruction <= imem_instruction`
  - `if_id_pc <= fetch_pc`
  - `if_id_valid <= fetch_valid`
  - `fetch_pc <= pc`
  - `fetch_valid <= 1`
  - `pc <= pc + 1`
- Arithmetic: PC increments by 1, because memory is word-addressed with one instruction per address. Addition is modulo 2^ADDR_W: address 32'hFFFFFFFF is followed by 0, with no flag raised.
- No other FSM. The effective state is {`fetch_valid`, `if_id_valid`}:
  - 00: after reset.
  - 10: first fetch in flight.
  - 11: steady-state streaming.
  - 10 again after a redirect.

## Timing
- Reset (asynchronous assert; release is synchronous to `clk` in the system):
  - `pc = RESET_PC`, `fetch_pc = 0`, `fetch_valid = 0`.
  - `if_id_instruction = 0`, `if_id_pc = 0`, `if_id_valid = 0`.
  - `imem_address = RESET_PC`, when `redirect` = 0 and `stall` = 0.
- Fetch latency is two edges from address presentation to IF/ID.
  - 1st edge after reset release: instruction @RESET_PC in flight.
  - 2nd edge: `if_id_instruction` = mem[RESET_PC], `if_id_valid` = 1.
- Throughput: one instruction per cycle when neither `stall` nor `redirect` is asserted.
- Redirect penalty: exactly one bubble (`if_id_valid` = 0 for one cycle). The target instruction is in IF/ID on the 2nd edge after `redirect`.
- Stall of N cycles:
  - `if_id_*` is unchanged for N edges.
  - `imem_address` equals `fetch_pc` during the stall.
  - On the first edge after the stall, the in-flight instruction is captured with no loss or duplication.
- `stall` and `redirect` in the same cycle: the redirect is taken and the stall is ignored.
- Reset asserted mid-stream: everything returns to reset values immediately, and in-flight data is discarded.

## Test plan
Memory preload: mem[k] = 16'h1000 + k.

- Reset release with `RESET_PC` = 0, no stall → `if_id_valid` rises at the 2nd edge. `if_id_instruction`/`if_id_pc` then read 1000/0, 1001/1, 1002/2, … on consecutive edges.
- Stall held for 3 cycles while IF/ID = 1003/3 → IF/ID holds 1003/3 for 3 edges. After the stall: 1004/4, then 1005/5, with no skip and no repeat.
- Redirect to 20 while IF/ID = 1005/5 → next edge `if_id_valid` = 0; following edges give 1014/20, 1015/21.
- `redirect` to 40 and `stall` asserted in the same cycle → the redirect wins; after one bubble, IF/ID = 1028/40.
- Redirect to 32'hFFFFFFFF with mem wrapping → IF/ID shows `if_id_pc` FFFFFFFF, then 0 on the next edge, with correct data.
- `rst_n` pulsed low mid-stream → all `if_id_*` outputs are 0 immediately (before the next edge) and `imem_address` = `RESET_PC`. Restart then behaves as in the first scenario.
